// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: terminator byte, host command codes and the
// frame serializer state encoding.
package debug_pkg;

    localparam logic [7:0] READY_CHAR = 8'h52;

    localparam logic [7:0] CMD_REGS   = 8'h01;
    localparam logic [7:0] CMD_IF_ID  = 8'h02;
    localparam logic [7:0] CMD_ID_EX  = 8'h03;
    localparam logic [7:0] CMD_EX_MEM = 8'h04;
    localparam logic [7:0] CMD_MEM_WB = 8'h05;
    localparam logic [7:0] CMD_STEP   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_TERM,
        ST_TWAIT,
        ST_FIN
    } frame_state_t;

    // Channel index width with one spare code so an out-of-range request
    // (i_sel >= NUM_CH) can actually be presented, even for power-of-two NUM_CH.
    function automatic int sel_width(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/debug_frame_tx_if.sv
// Request / uart_tx handshake bundle between the debug unit and the frame
// serializer. master = requester + uart side, slave = serializer.
interface debug_frame_tx_if #(
    parameter int MAX_BYTES = 17,
    parameter int NUM_CH    = 4
);
    import debug_pkg::*;

    localparam int SEL_W  = sel_width(NUM_CH);
    localparam int LEN_W  = $clog2(MAX_BYTES + 1);
    localparam int DATA_W = NUM_CH * 8 * MAX_BYTES;

    logic              i_start;
    logic [SEL_W-1:0]  i_sel;
    logic [LEN_W-1:0]  i_len;
    logic [DATA_W-1:0] i_data;
    logic [7:0]        o_tx_data;
    logic              o_tx_start;
    logic              i_tx_done;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        output i_start, i_sel, i_len, i_data, i_tx_done,
        input  o_tx_data, o_tx_start, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_sel, i_len, i_data, i_tx_done,
        output o_tx_data, o_tx_start, o_busy, o_done, o_err
    );

endinterface

// File: rtl/debug_frame_tx_byte_sel.sv
// Combinational byte mux: picks byte idx out of a channel snapshot,
// byte 0 being bits [7:0].
module frame_byte_sel #(
    parameter int MAX_BYTES = 17,
    parameter int IDX_W     = 5
) (
    input  logic [8*MAX_BYTES-1:0] snap,
    input  logic [IDX_W-1:0]       idx,
    output logic [7:0]             byte_out
);

    // Out-of-range indices return zero; the FSM never requests them.
    always_comb begin
        byte_out = 8'h00;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (idx == IDX_W'(b)) byte_out = snap[8*b +: 8];
        end
    end

endmodule

// File: rtl/debug_frame_tx.sv
// Debug-dump serializer: snapshots one channel on request and feeds it
// byte by byte (LSB first) to uart_tx, optionally followed by READY_CHAR.
//
// state | meaning
// IDLE  | waiting for i_start
// SEND  | o_tx_start high for a payload byte
// WAIT  | payload byte in flight, waiting for i_tx_done
// TERM  | o_tx_start high for READY_CHAR
// TWAIT | READY_CHAR in flight, waiting for i_tx_done
// FIN   | o_done cycle (empty frame without terminator spends one extra
//       | busy cycle here first)
module debug_frame_tx #(
    parameter int         MAX_BYTES    = 17,
    parameter int         NUM_CH       = 4,
    parameter int         APPEND_READY = 1,
    parameter logic [7:0] READY_CHAR   = debug_pkg::READY_CHAR
) (
    input logic              i_clk,
    input logic              i_rst,
    debug_frame_tx_if.slave  bus
);
    import debug_pkg::*;

    localparam int              CH_W    = 8 * MAX_BYTES;
    localparam int              SEL_W   = sel_width(NUM_CH);
    localparam int              LEN_W   = $clog2(MAX_BYTES + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

    frame_state_t     state;
    logic [CH_W-1:0]  snap;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;

    logic [CH_W-1:0]  chan_in;
    logic [CH_W-1:0]  mux_src;
    logic [LEN_W-1:0] mux_idx;
    logic [7:0]       mux_byte;
    logic [LEN_W-1:0] len_clip;
    logic [LEN_W-1:0] idx_nxt;

    // Live channel selected by i_sel, used for the first byte and the snapshot.
    always_comb begin
        chan_in = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.i_sel == SEL_W'(c)) chan_in = bus.i_data[c*CH_W +: CH_W];
        end
    end

    // Next byte source: live data when starting, frozen snapshot afterwards.
    always_comb begin
        len_clip = (bus.i_len > LEN_MAX) ? LEN_MAX : bus.i_len;
        idx_nxt  = idx + LEN_W'(1);
        mux_src  = (state == ST_IDLE) ? chan_in : snap;
        mux_idx  = (state == ST_IDLE) ? '0 : idx_nxt;
    end

    frame_byte_sel #(
        .MAX_BYTES (MAX_BYTES),
        .IDX_W     (LEN_W)
    ) u_byte_sel (
        .snap     (mux_src),
        .idx      (mux_idx),
        .byte_out (mux_byte)
    );

    // Frame sequencing with registered handshake and status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            snap           <= '0;
            len            <= '0;
            idx            <= '0;
            bus.o_tx_data  <= 8'h00;
            bus.o_tx_start <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_err      <= 1'b0;
        end else begin
            bus.o_tx_start <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_sel >= SEL_W'(NUM_CH)) begin
                            bus.o_err <= 1'b1;
                        end else begin
                            snap       <= chan_in;
                            len        <= len_clip;
                            idx        <= '0;
                            bus.o_busy <= 1'b1;
                            if (len_clip != '0) begin
                                state          <= ST_SEND;
                                bus.o_tx_start <= 1'b1;
                                bus.o_tx_data  <= mux_byte;
                            end else if (APPEND_READY != 0) begin
                                state          <= ST_TERM;
                                bus.o_tx_start <= 1'b1;
                                bus.o_tx_data  <= READY_CHAR;
                            end else begin
                                state <= ST_FIN;
                            end
                        end
                    end
                end
                ST_SEND: state <= ST_WAIT;
                ST_WAIT: begin
                    if (bus.i_tx_done) begin
                        idx <= idx_nxt;
                        if (idx_nxt == len) begin
                            if (APPEND_READY != 0) begin
                                state          <= ST_TERM;
                                bus.o_tx_start <= 1'b1;
                                bus.o_tx_data  <= READY_CHAR;
                            end else begin
                                state      <= ST_FIN;
                                bus.o_done <= 1'b1;
                                bus.o_busy <= 1'b0;
                            end
                        end else begin
                            state          <= ST_SEND;
                            bus.o_tx_start <= 1'b1;
                            bus.o_tx_data  <= mux_byte;
                        end
                    end
                end
                ST_TERM: state <= ST_TWAIT;
                ST_TWAIT: begin
                    if (bus.i_tx_done) begin
                        state      <= ST_FIN;
                        bus.o_done <= 1'b1;
                        bus.o_busy <= 1'b0;
                    end
                end
                ST_FIN: begin
                    if (bus.o_busy) begin
                        bus.o_done <= 1'b1;
                        bus.o_busy <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: frame-level model + uart_tx responder + directed tests.
module tb_debug_frame_tx;

    localparam int MAXB = 17;
    localparam int NCH  = 4;
    localparam int CHW  = 8 * MAXB;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    debug_frame_tx_if #(.MAX_BYTES(MAXB), .NUM_CH(NCH)) if_a ();
    debug_frame_tx_if #(.MAX_BYTES(MAXB), .NUM_CH(NCH)) if_b ();

    debug_frame_tx #(.MAX_BYTES(MAXB), .NUM_CH(NCH), .APPEND_READY(1), .READY_CHAR(8'h52))
        u_dut (.i_clk(i_clk), .i_rst(i_rst), .bus(if_a));

    debug_frame_tx #(.MAX_BYTES(MAXB), .NUM_CH(NCH), .APPEND_READY(0), .READY_CHAR(8'h52))
        u_dut_nr (.i_clk(i_clk), .i_rst(i_rst), .bus(if_b));

    always #5 i_clk = ~i_clk;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [CHW-1:0] ch_mdl [NCH];
    logic [7:0]     exp_q[$];
    bit             frame_on = 0;
    bit             in_flight = 0;
    logic [7:0]     cur_byte = 8'h00;
    int             start_cyc = -1;
    int             next_start_cyc = -1;
    int             next_done_cyc = -1;
    int             err_cyc = -1;

    initial begin : compare
        bit e_start, e_done, e_busy, e_err, was_on;
        int n;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                chk("rst_tx_start", if_a.o_tx_start, 0);
                chk("rst_busy", if_a.o_busy, 0);
                chk("rst_done", if_a.o_done, 0);
                chk("rst_err", if_a.o_err, 0);
                chk("rst_tx_data", if_a.o_tx_data, 0);
                frame_on = 0;
                in_flight = 0;
                exp_q.delete();
                err_cyc = -1;
                next_done_cyc = -1;
            end else begin
                e_start = frame_on && !in_flight && (exp_q.size() > 0) && (cyc == next_start_cyc);
                e_done  = frame_on && (cyc == next_done_cyc);
                e_busy  = frame_on && (cyc > start_cyc) && !e_done;
                e_err   = (cyc == err_cyc);
                chk("tx_start", if_a.o_tx_start, e_start);
                chk("done", if_a.o_done, e_done);
                chk("busy", if_a.o_busy, e_busy);
                chk("err", if_a.o_err, e_err);
                if (e_start) begin
                    cur_byte = exp_q.pop_front();
                    in_flight = 1;
                end
                if (in_flight) chk("tx_data", if_a.o_tx_data, cur_byte);
                was_on = frame_on;
                if (e_done) frame_on = 0;
                if (in_flight && if_a.i_tx_done) begin
                    in_flight = 0;
                    if (exp_q.size() > 0) next_start_cyc = cyc + 1;
                    else next_done_cyc = cyc + 1;
                end
                if (if_a.i_start && !was_on) begin
                    if (int'(if_a.i_sel) >= NCH) begin
                        err_cyc = cyc + 1;
                    end else begin
                        n = (int'(if_a.i_len) > MAXB) ? MAXB : int'(if_a.i_len);
                        for (int b = 0; b < n; b++) exp_q.push_back(ch_mdl[if_a.i_sel][8*b +: 8]);
                        exp_q.push_back(8'h52);
                        frame_on = 1;
                        in_flight = 0;
                        start_cyc = cyc;
                        next_start_cyc = cyc + 1;
                        next_done_cyc = -1;
                    end
                end
            end
        end
    end

    // ---------------- uart_tx responder and logger ----------------
    int         tx_delay = 10;
    int         dly_cnt = 0;
    logic [7:0] sent_q[$];
    int         sent_cyc_q[$];
    int         done_seen = 0;
    int         err_seen_cyc = -1;

    initial begin : uart_resp
        if_a.i_tx_done = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if_a.i_tx_done = 1'b0;
            if (i_rst) begin
                dly_cnt = 0;
            end else begin
                if (dly_cnt > 0) begin
                    dly_cnt--;
                    if (dly_cnt == 0) if_a.i_tx_done = 1'b1;
                end
                if (if_a.o_tx_start) begin
                    sent_q.push_back(if_a.o_tx_data);
                    sent_cyc_q.push_back(cyc);
                    dly_cnt = tx_delay;
                end
                if (if_a.o_done) done_seen++;
                if (if_a.o_err) err_seen_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input int sel, input int len, output int s);
        @(posedge i_clk);
        #1;
        if_a.i_start = 1'b1;
        if_a.i_sel   = 3'(sel);
        if_a.i_len   = 5'(len);
        s = cyc;
        @(posedge i_clk);
        #1;
        if_a.i_start = 1'b0;
    endtask

    task automatic clear_logs();
        @(negedge i_clk);
        sent_q.delete();
        sent_cyc_q.delete();
        done_seen = 0;
        err_seen_cyc = -1;
    endtask

    task automatic wait_sent(input int n, input int budget);
        int k = 0;
        while (sent_q.size() < n && k < budget) begin
            @(negedge i_clk);
            k++;
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_seen == 0 && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        repeat (3) @(negedge i_clk);
    endtask

    task automatic load_chan(input int c, input logic [CHW-1:0] v);
        ch_mdl[c] = v;
        if_a.i_data[c*CHW +: CHW] = v;
    endtask

    // ---------------- directed tests ----------------
    initial begin : stim
        int s, d;
        logic [CHW-1:0] v;
        if_a.i_start = 1'b0;
        if_a.i_sel   = '0;
        if_a.i_len   = '0;
        if_a.i_data  = '0;
        if_b.i_start = 1'b0;
        if_b.i_sel   = '0;
        if_b.i_len   = '0;
        if_b.i_data  = '0;
        if_b.i_tx_done = 1'b0;
        for (int c = 0; c < NCH; c++) ch_mdl[c] = '0;

        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_busy", if_a.o_busy, 0);
        chk("reset_tx_start", if_a.o_tx_start, 0);
        chk("reset_nr_done", if_b.o_done, 0);
        i_rst = 1'b0;

        // 1: four-byte word, tx_done 10 cycles after each start
        load_chan(0, CHW'(32'h3C010003));
        tx_delay = 10;
        clear_logs();
        start_frame(0, 4, s);
        wait_done(200);
        chk("t1_count", sent_q.size(), 5);
        if (sent_q.size() == 5) begin
            chk("t1_b0", sent_q[0], 8'h03);
            chk("t1_b1", sent_q[1], 8'h00);
            chk("t1_b2", sent_q[2], 8'h01);
            chk("t1_b3", sent_q[3], 8'h3C);
            chk("t1_b4", sent_q[4], 8'h52);
            chk("t1_first_lat", sent_cyc_q[0], s + 1);
        end
        chk("t1_done_cnt", done_seen, 1);

        // 2: full 17-byte channel, plus an ignored start while busy
        for (int b = 0; b < MAXB; b++) v[8*b +: 8] = 8'(b);
        load_chan(1, v);
        clear_logs();
        start_frame(1, 17, s);
        wait_sent(3, 100);
        start_frame(2, 3, d);
        wait_done(400);
        chk("t2_count", sent_q.size(), 18);
        if (sent_q.size() == 18) begin
            for (int b = 0; b < MAXB; b++) chk("t2_byte", sent_q[b], b);
            chk("t2_term", sent_q[17], 8'h52);
            for (int i = 0; i < 17; i++) chk("t2_spacing", sent_cyc_q[i+1] - sent_cyc_q[i], 11);
        end
        chk("t2_done_cnt", done_seen, 1);

        // 3a: empty payload with terminator
        clear_logs();
        start_frame(0, 0, s);
        wait_done(50);
        chk("t3_count", sent_q.size(), 1);
        if (sent_q.size() == 1) begin
            chk("t3_term", sent_q[0], 8'h52);
            chk("t3_lat", sent_cyc_q[0], s + 1);
        end
        chk("t3_done_cnt", done_seen, 1);

        // 3b: empty payload without terminator
        @(posedge i_clk);
        #1;
        if_b.i_start = 1'b1;
        s = cyc;
        @(posedge i_clk);
        #1;
        if_b.i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("t3b_tx_start", if_b.o_tx_start, 0);
            chk("t3b_done", if_b.o_done, (cyc == s + 2));
            chk("t3b_busy", if_b.o_busy, (cyc == s + 1));
        end

        // 4: out-of-range channel
        clear_logs();
        start_frame(5, 4, s);
        repeat (5) @(negedge i_clk);
        chk("t4_err_cyc", err_seen_cyc, s + 1);
        chk("t4_count", sent_q.size(), 0);
        chk("t4_done_cnt", done_seen, 0);

        // 5: over-long request, data changed mid-frame
        for (int b = 0; b < MAXB; b++) v[8*b +: 8] = 8'(8'hA0 + b);
        load_chan(2, v);
        tx_delay = 3;
        clear_logs();
        start_frame(2, 20, s);
        wait_sent(3, 100);
        load_chan(2, ~v);
        wait_done(200);
        chk("t5_count", sent_q.size(), 18);
        if (sent_q.size() == 18) begin
            for (int b = 0; b < MAXB; b++) chk("t5_byte", sent_q[b], 8'(8'hA0 + b));
            chk("t5_last", sent_q[16], 8'hB0);
            chk("t5_term", sent_q[17], 8'h52);
        end

        // 6: reset mid-frame, then a fresh complete frame
        load_chan(3, CHW'(64'h8877665544332211));
        clear_logs();
        start_frame(3, 8, s);
        wait_sent(3, 100);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("t6_rst_busy", if_a.o_busy, 0);
        chk("t6_rst_tx_start", if_a.o_tx_start, 0);
        chk("t6_rst_done", if_a.o_done, 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("t6_abort_no_done", done_seen, 0);
        clear_logs();
        start_frame(3, 8, s);
        wait_done(100);
        chk("t6_count", sent_q.size(), 9);
        if (sent_q.size() == 9) begin
            chk("t6_b0", sent_q[0], 8'h11);
            chk("t6_b7", sent_q[7], 8'h88);
            chk("t6_term", sent_q[8], 8'h52);
        end
        chk("t6_done_cnt", done_seen, 1);

        repeat (3) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
